if_phase: RTL



---
 rtl/if_phase.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/if_phase.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake,
// and drives the IF/ID register. Define IF_HOLD_BUF_EN to buffer a word fetched during a stall.
module if_phase #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPc,
  output logic        o_imemReq,
  output logic [31:0] o_imemAddr,
  input  logic        i_imemAck,
  input  logic [31:0] i_imemData,
  output logic [31:0] o_instr,
  output logic [31:0] o_fetchPc4,
  output logic        o_instrValid
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_KILL  = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pendPc;
  logic [31:0] r_instr;
  logic [31:0] r_fetchPc4;
  logic        r_instrValid;

  logic [31:0] w_pc4;
  logic [31:0] w_redirTgt;

  assign w_pc4      = r_pc + 32'd4;
  assign w_redirTgt = {i_redirectPc[31:2], 2'b00};

  // Request is gated by reset so it drops immediately, without waiting for an edge.
  assign o_imemReq    = !i_rst && (r_state != S_HOLD);
  assign o_imemAddr   = r_pc;
  assign o_instr      = r_instr;
  assign o_fetchPc4   = r_fetchPc4;
  assign o_instrValid = r_instrValid;

`ifdef IF_HOLD_BUF_EN
  logic [31:0] r_bufData;
  logic [31:0] r_bufPc4;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_pendPc     <= RESET_PC;
      r_instr      <= NOP_INSTR;
      r_fetchPc4   <= 32'd0;
      r_instrValid <= 1'b0;
`ifdef IF_HOLD_BUF_EN
      r_bufData    <= NOP_INSTR;
      r_bufPc4     <= 32'd0;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          if (i_redirect) begin
            r_instr      <= NOP_INSTR;
            r_fetchPc4   <= 32'd0;
            r_instrValid <= 1'b0;
            if (i_imemAck) begin
              r_pc <= w_redirTgt;
            end else begin
              r_pendPc <= w_redirTgt;
              r_state  <= S_KILL;
            end
          end else if (i_flush) begin
            // The word arriving now follows the flushed instruction: skip it.
            r_instr      <= NOP_INSTR;
            r_fetchPc4   <= 32'd0;
            r_instrValid <= 1'b0;
            if (i_imemAck) r_pc <= w_pc4;
          end else if (i_stall) begin
`ifdef IF_HOLD_BUF_EN
            if (i_imemAck) begin
              r_bufData <= i_imemData;
              r_bufPc4  <= w_pc4;
              r_state   <= S_HOLD;
            end
`else
            // Word dropped; the same address is re-requested until it lands unstalled.
            r_state <= S_FETCH;
`endif
          end else if (i_imemAck) begin
            r_instr      <= i_imemData;
            r_fetchPc4   <= w_pc4;
            r_instrValid <= 1'b1;
            r_pc         <= w_pc4;
          end
        end

        S_KILL: begin
          if (i_redirect) begin
            r_instr      <= NOP_INSTR;
            r_fetchPc4   <= 32'd0;
            r_instrValid <= 1'b0;
            if (i_imemAck) begin
              r_pc    <= w_redirTgt;
              r_state <= S_FETCH;
            end else begin
              r_pendPc <= w_redirTgt;
            end
          end else begin
            if (i_flush) begin
              r_instr      <= NOP_INSTR;
              r_fetchPc4   <= 32'd0;
              r_instrValid <= 1'b0;
            end
            if (i_imemAck) begin
              r_pc    <= r_pendPc;
              r_state <= S_FETCH;
            end
          end
        end

`ifdef IF_HOLD_BUF_EN
        S_HOLD: begin
          if (i_redirect) begin
            r_instr      <= NOP_INSTR;
            r_fetchPc4   <= 32'd0;
            r_instrValid <= 1'b0;
            r_pc         <= w_redirTgt;
            r_state      <= S_FETCH;
          end else if (i_flush) begin
            r_instr      <= NOP_INSTR;
            r_fetchPc4   <= 32'd0;
            r_instrValid <= 1'b0;
            r_pc         <= w_pc4;
            r_state      <= S_FETCH;
          end else if (!i_stall) begin
            r_instr      <= r_bufData;
            r_fetchPc4   <= r_bufPc4;
            r_instrValid <= 1'b1;
            r_pc         <= w_pc4;
            r_state      <= S_FETCH;
          end
        end
`endif

        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule
